// File: rtl/msg_schedule.sv
// SHA-2 message schedule: loads 16 message words, then expands to ROUNDS words
// through a 16-entry sliding window, one word per handshake.
module msg_schedule #(
    parameter int WIDTH  = 32,
    parameter int ROUNDS = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] D_IN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] D_OUT,
    output logic [6:0]       I_OUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_EXPAND = 2'd2;

    localparam int unsigned S0_R1 = (WIDTH == 64) ? 1  : 7;
    localparam int unsigned S0_R2 = (WIDTH == 64) ? 8  : 18;
    localparam int unsigned S0_SH = (WIDTH == 64) ? 7  : 3;
    localparam int unsigned S1_R1 = (WIDTH == 64) ? 19 : 17;
    localparam int unsigned S1_R2 = (WIDTH == 64) ? 61 : 19;
    localparam int unsigned S1_SH = (WIDTH == 64) ? 6  : 10;

    localparam logic [6:0] LAST_IDX   = 7'(ROUNDS - 1);
    localparam logic [6:0] END_IDX    = 7'(ROUNDS);
    localparam bit         HAS_EXPAND = (ROUNDS > 16);

    logic [1:0]           r_state;
    logic [16*WIDTH-1:0]  r_win;      // w0 in the low word, w15 in the high word
    logic [WIDTH-1:0]     r_dout;
    logic [6:0]           r_iout;
    logic [6:0]           r_idx;
    logic                 r_ovalid;
    logic                 r_done;

    logic [WIDTH-1:0]     w_w0, w_w1, w_w9, w_w14;
    logic [WIDTH-1:0]     w_s0, w_s1, w_sum, w_next;
    logic                 w_free, w_in_ok, w_in_hs, w_gen, w_last_hs, w_shift;

    assign w_w0  = r_win[0*WIDTH +: WIDTH];
    assign w_w1  = r_win[1*WIDTH +: WIDTH];
    assign w_w9  = r_win[9*WIDTH +: WIDTH];
    assign w_w14 = r_win[14*WIDTH +: WIDTH];

    assign w_s0 = ((w_w1 >> S0_R1) | (w_w1 << (WIDTH - S0_R1)))
                ^ ((w_w1 >> S0_R2) | (w_w1 << (WIDTH - S0_R2)))
                ^ (w_w1 >> S0_SH);
    assign w_s1 = ((w_w14 >> S1_R1) | (w_w14 << (WIDTH - S1_R1)))
                ^ ((w_w14 >> S1_R2) | (w_w14 << (WIDTH - S1_R2)))
                ^ (w_w14 >> S1_SH);
    assign w_sum = w_s1 + w_w9 + w_s0 + w_w0;

    assign w_free    = !r_ovalid || OUT_READY;
    // Index guard keeps a 16-round block from taking a 17th word while its last output waits.
    assign w_in_ok   = (r_state == S_LOAD) && w_free && (r_idx < 7'd16);
    assign IN_READY  = !RST && w_in_ok;
    assign w_in_hs   = IN_VALID && w_in_ok;
    assign w_gen     = (r_state == S_EXPAND) && w_free && (r_idx != END_IDX);
    assign w_last_hs = r_ovalid && OUT_READY && (r_iout == LAST_IDX);
    assign w_shift   = w_in_hs || w_gen;
    assign w_next    = w_in_hs ? D_IN : w_sum;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_win    <= '0;
            r_dout   <= '0;
            r_iout   <= '0;
            r_idx    <= '0;
            r_ovalid <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_last_hs;
            if (r_ovalid && OUT_READY) begin
                r_ovalid <= 1'b0;
            end
            if (w_shift) begin
                r_dout   <= w_next;
                r_iout   <= r_idx;
                r_ovalid <= 1'b1;
                r_idx    <= r_idx + 7'd1;
                r_win    <= {w_next, r_win[16*WIDTH-1:WIDTH]};
            end
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_state <= S_LOAD;
                        r_idx   <= '0;
                    end
                end
                S_LOAD: begin
                    if (HAS_EXPAND && w_in_hs && (r_idx == 7'd15)) begin
                        r_state <= S_EXPAND;
                    end else if (w_last_hs) begin
                        r_state <= S_IDLE;
                    end
                end
                S_EXPAND: begin
                    if (w_last_hs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign OUT_VALID = r_ovalid;
    assign D_OUT     = r_dout;
    assign I_OUT     = r_iout;
    assign BUSY      = (r_state != S_IDLE);
    assign DONE      = r_done;

endmodule

// File: tb/tb_msg_schedule.sv
// Bench for msg_schedule: three instances (SHA-256, SHA-512, 16-round) checked
// every cycle against a schedule computed directly from the SHA-2 recurrence.
module tb_msg_schedule;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  t_start, t_ivalid, t_oready;
    logic [63:0] t_din;

    logic [2:0]  v_iready, v_ovalid, v_busy, v_done;
    logic [63:0] v_dout [3];
    logic [6:0]  v_iout [3];
    logic [31:0] d0, d2;
    logic [63:0] d1;

    assign v_dout[0] = {32'd0, d0};
    assign v_dout[1] = d1;
    assign v_dout[2] = {32'd0, d2};

    msg_schedule #(.WIDTH(32), .ROUNDS(64)) u_sha256 (
        .CLK(clk), .RST(rst), .START(t_start[0]), .IN_VALID(t_ivalid[0]),
        .IN_READY(v_iready[0]), .D_IN(t_din[31:0]), .OUT_VALID(v_ovalid[0]),
        .OUT_READY(t_oready[0]), .D_OUT(d0), .I_OUT(v_iout[0]),
        .BUSY(v_busy[0]), .DONE(v_done[0]));

    msg_schedule #(.WIDTH(64), .ROUNDS(80)) u_sha512 (
        .CLK(clk), .RST(rst), .START(t_start[1]), .IN_VALID(t_ivalid[1]),
        .IN_READY(v_iready[1]), .D_IN(t_din), .OUT_VALID(v_ovalid[1]),
        .OUT_READY(t_oready[1]), .D_OUT(d1), .I_OUT(v_iout[1]),
        .BUSY(v_busy[1]), .DONE(v_done[1]));

    msg_schedule #(.WIDTH(32), .ROUNDS(16)) u_r16 (
        .CLK(clk), .RST(rst), .START(t_start[2]), .IN_VALID(t_ivalid[2]),
        .IN_READY(v_iready[2]), .D_IN(t_din[31:0]), .OUT_VALID(v_ovalid[2]),
        .OUT_READY(t_oready[2]), .D_OUT(d2), .I_OUT(v_iout[2]),
        .BUSY(v_busy[2]), .DONE(v_done[2]));

    int          n_chk = 0;
    int          n_err = 0;
    int          rounds [3] = '{64, 80, 16};
    int          wid    [3] = '{32, 64, 32};
    logic [63:0] mdl [3][128];
    logic [63:0] cur_msg [16];
    logic [63:0] cap [128];

    int          exp_idx [3];
    bit          prev_last [3], prev_stall [3];
    logic [63:0] pdout [3];
    logic [6:0]  piout [3];
    bit          s_inhs [3], s_ouths [3], s_done [3], s_busy [3], s_iready [3];
    logic [63:0] s_dout [3];
    logic [6:0]  s_iout [3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
        logic [31:0] y;
        if (w == 32) begin
            y = x[31:0];
            return {32'd0, (y >> n) | (y << (32 - n))};
        end
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] sig0(input logic [63:0] x, input int w);
        if (w == 32) return rotr(x, 7, w) ^ rotr(x, 18, w) ^ (x >> 3);
        return rotr(x, 1, w) ^ rotr(x, 8, w) ^ (x >> 7);
    endfunction

    function automatic logic [63:0] sig1(input logic [63:0] x, input int w);
        if (w == 32) return rotr(x, 17, w) ^ rotr(x, 19, w) ^ (x >> 10);
        return rotr(x, 19, w) ^ rotr(x, 61, w) ^ (x >> 6);
    endfunction

    task automatic build_model(input int k);
        logic [63:0] mask;
        mask = (wid[k] == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
        for (int t = 0; t < 16; t++) mdl[k][t] = cur_msg[t] & mask;
        for (int t = 16; t < 128; t++)
            mdl[k][t] = (sig1(mdl[k][t-2], wid[k]) + mdl[k][t-7]
                       + sig0(mdl[k][t-15], wid[k]) + mdl[k][t-16]) & mask;
    endtask

    // Sampled mid-cycle: the values seen here are what the next rising edge acts on.
    task automatic mon();
        for (int k = 0; k < 3; k++) begin
            s_inhs[k]   = t_ivalid[k] && v_iready[k];
            s_ouths[k]  = v_ovalid[k] && t_oready[k];
            s_done[k]   = v_done[k];
            s_busy[k]   = v_busy[k];
            s_iready[k] = v_iready[k];
            s_dout[k]   = v_dout[k];
            s_iout[k]   = v_iout[k];
            if (rst) begin
                exp_idx[k] = 0; prev_last[k] = 0; prev_stall[k] = 0;
                s_inhs[k] = 0; s_ouths[k] = 0; s_done[k] = 0;
                continue;
            end
            chk($sformatf("u%0d_done", k), v_done[k], prev_last[k]);
            if (prev_stall[k]) begin
                chk($sformatf("u%0d_stall_dout", k), v_dout[k], pdout[k]);
                chk($sformatf("u%0d_stall_iout", k), v_iout[k], piout[k]);
            end
            prev_stall[k] = v_ovalid[k] && !t_oready[k];
            if (prev_stall[k]) chk($sformatf("u%0d_stall_inready", k), v_iready[k], 0);
            if (t_start[k] && !v_busy[k]) exp_idx[k] = 0;
            prev_last[k] = 0;
            if (s_ouths[k]) begin
                chk($sformatf("u%0d_iout", k), v_iout[k], exp_idx[k]);
                chk($sformatf("u%0d_dout_w%0d", k, v_iout[k]), v_dout[k], mdl[k][v_iout[k]]);
                if (int'(v_iout[k]) == rounds[k] - 1) prev_last[k] = 1;
                exp_idx[k]++;
            end
            pdout[k] = v_dout[k];
            piout[k] = v_iout[k];
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input int k, input bit rnd, input bit do_start,
                             input bit start_mid, input bit start_done, input int abort_at);
        int n_in = 0, n_out = 0;
        bit got_done = 0, pend = 0, aborted = 0, was_full;
        build_model(k);
        for (int i = 0; i < 128; i++) cap[i] = '0;
        if (do_start) begin
            t_start[k] = 1'b1;
            tick();
            t_start[k] = 1'b0;
        end
        for (int cyc = 0; cyc < 4000 && !got_done && !aborted; cyc++) begin
            t_start[k] = pend;
            pend = 0;
            was_full = (n_in >= 16);
            if (was_full) t_ivalid[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            else          t_ivalid[k] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            t_din = cur_msg[n_in % 16];
            t_oready[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (s_inhs[k]) n_in++;
            if (was_full) chk("in_ready_after_load", s_iready[k], 0);
            if (s_ouths[k]) begin
                n_out++;
                cap[s_iout[k]] = s_dout[k];
                if (start_mid && s_iout[k] == 7'd20) pend = 1;
                if (start_done && int'(s_iout[k]) == rounds[k] - 1) pend = 1;
            end
            if (s_done[k]) begin
                got_done = 1;
                chk("idle_in_done_cycle", s_busy[k], 0);
            end
            if (abort_at >= 0 && v_ovalid[k] && int'(v_iout[k]) == abort_at) begin
                aborted = 1;
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk("abort_dout", v_dout[k], 0);
                chk("abort_iout", v_iout[k], 0);
                chk("abort_ovalid", v_ovalid[k], 0);
                chk("abort_busy", v_busy[k], 0);
                chk("abort_done", v_done[k], 0);
            end
        end
        t_start[k]  = 1'b0;
        t_ivalid[k] = 1'b0;
        if (aborted) begin
            t_oready[k] = 1'b1;
            tick();
            tick();
        end else begin
            chk("done_seen", got_done, 1);
            chk("word_count", n_out, rounds[k]);
            if (start_done) begin
                chk("restart_busy", v_busy[k], 1);
                chk("restart_inready", v_iready[k], 1);
            end
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) cur_msg[i] = '0;
        cur_msg[0]  = 64'h6162_6380;
        cur_msg[15] = 64'h0000_0018;
    endtask

    task automatic set_rand();
        for (int i = 0; i < 16; i++) cur_msg[i] = {$urandom, $urandom};
    endtask

    initial begin
        rst = 1'b1;
        t_start = '0; t_ivalid = '0; t_oready = '1; t_din = '0;
        tick();
        chk("inready_in_reset", v_iready, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("reset_dout", v_dout[k], 0);
            chk("reset_iout", v_iout[k], 0);
            chk("reset_ovalid", v_ovalid[k], 0);
            chk("reset_busy", v_busy[k], 0);
            chk("reset_done", v_done[k], 0);
        end

        set_abc();
        build_model(0);
        chk("model_abc_w16", mdl[0][16], 64'h6162_6380);
        chk("model_abc_w17", mdl[0][17], 64'h000F_0000);
        run_block(0, 0, 1, 0, 0, -1);
        chk("abc_w16", cap[16], 64'h6162_6380);
        chk("abc_w17", cap[17], 64'h000F_0000);

        run_block(0, 1, 1, 0, 0, -1);
        chk("abc_stalled_w17", cap[17], 64'h000F_0000);

        set_rand();
        run_block(0, 1, 1, 1, 1, -1);
        set_rand();
        run_block(0, 1, 0, 0, 0, -1);

        set_abc();
        run_block(0, 1, 1, 0, 0, 30);
        run_block(0, 0, 1, 0, 0, -1);
        chk("after_abort_w17", cap[17], 64'h000F_0000);

        for (int i = 0; i < 16; i++) cur_msg[i] = '0;
        cur_msg[0] = 64'd1;
        run_block(1, 0, 1, 0, 0, -1);
        chk("model512_w18", mdl[1][18], 64'h0000_2000_0000_0008);
        chk("sha512_w16", cap[16], 64'd1);
        chk("sha512_w17", cap[17], 64'd0);
        chk("sha512_w18", cap[18], 64'h0000_2000_0000_0008);
        set_rand();
        run_block(1, 1, 1, 0, 0, -1);

        set_rand();
        run_block(2, 1, 1, 0, 0, -1);
        chk("r16_last_word", cap[15], {32'd0, cur_msg[15][31:0]});
        set_rand();
        run_block(2, 0, 1, 0, 1, -1);
        set_rand();
        run_block(2, 1, 0, 0, 0, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
